instr_mem_prog: RTL and testbench
=================================

# instr_mem_prog

Parametrised, programmable instruction memory for the single-cycle RISC-V core. It replaces hard-coded reset contents with two mechanisms:
- a post-reset clear sweep that fills every word with a NOP;
- a byte-serial programming port that loads a program into consecutive words.

Fetches are registered, one-cycle latency, and carry fault flags for misaligned and out-of-range addresses.

## Interface
Parameters:
- DEPTH, 64, number of WORD_W-bit words; power of two, ≥ 4
- ADDR_W, 32, width of the byte address
- WORD_W, 32, instruction width; multiple of 8
- FILL_WORD, 32'h00000013, value written by the clear sweep and returned on faults (addi x0,x0,0)

Ports:
- clk, input, 1, sole clock, rising edge
- reset, input, 1, synchronous, active-high
- prog_en, input, 1, level; high requests or holds LOAD mode
- prog_valid, input, 1, prog_byte is valid this cycle
- prog_byte, input, 8, programming data, little-endian within a word
- prog_ready, output, 1, byte accepted when prog_valid && prog_ready
- prog_overflow, output, 1, sticky; a full word was presented with the memory already full
- words_loaded, output, $clog2(DEPTH+1), words written in the current or last LOAD session
- busy, output, 1, high in CLEAR or LOAD
- fetch_req, input, 1, fetch request
- read_address, input, ADDR_W, byte address of the fetch
- instruction_out, output, WORD_W, fetched word
- instr_valid, output, 1, one-cycle pulse; instruction_out is valid
- misaligned, output, 1, qualifies instr_valid; read_address[1:0] != 0
- out_of_range, output, 1, qualifies instr_valid; read_address>>2 >= DEPTH

## Operation
State machine: CLEAR, READY, LOAD.

CLEAR
- Entered on reset.
- Each cycle writes FILL_WORD at clr_ptr, then increments clr_ptr.
- After writing index DEPTH-1, goes to READY. The sweep lasts exactly DEPTH cycles.
- prog_en is ignored; fetches are dropped.

READY
- prog_en = 1 → LOAD. The same cycle's fetch is dropped.
- Otherwise fetch_req = 1 is serviced. Index = read_address >> 2.
- Faults:
  - misaligned takes precedence over out_of_range.
  - Either fault returns FILL_WORD and performs no array read.

LOAD
- On entry: wr_ptr = 0, byte lane = 0, words_loaded = 0, prog_overflow = 0.
- Each accepted byte goes into lane k (bits 8k+7:8k) of the assembly register.
- When lane WORD_W/8-1 is accepted:
  - if wr_ptr < DEPTH: the word is written at wr_ptr, wr_ptr and words_loaded increment;
  - if wr_ptr = DEPTH: prog_overflow is set and the word is discarded. prog_ready stays 1, so bytes are consumed and dropped.
- prog_en = 0 → READY next cycle. A partially assembled word is discarded.
- Words at index ≥ words_loaded keep their previous contents.
- Fetches are dropped.

Memory contents are not reset in one cycle; only the sweep initialises them.

## Timing
Reset values, held while reset = 1:
- state = CLEAR; clr_ptr, wr_ptr, lane = 0
- prog_ready = 0, prog_overflow = 0, words_loaded = 0, busy = 1
- instr_valid = 0, misaligned = 0, out_of_range = 0, instruction_out = FILL_WORD

Cycle-level behaviour:
- Reset mid-LOAD or mid-CLEAR aborts it and restarts CLEAR.
- Fetch latency: request at edge N → instr_valid, instruction_out and fault flags registered at edge N+1, valid for one cycle.
- Back-to-back fetches give back-to-back responses.
- instruction_out holds its last value when instr_valid = 0.
- prog_ready is combinational from state: 1 iff state = LOAD. It is low in the LOAD→READY cycle after prog_en drops.
- The array write of a completed word occurs at the edge accepting its last byte. It is visible to the first fetch serviced after return to READY (the earliest possible).
- busy is registered with the state.

## Test plan
- Reset, then idle DEPTH cycles (DEPTH=64): busy = 1 for exactly 64 cycles. Then fetch 0x0, 0x4, 0xFC → each returns 0x00000013, instr_valid one cycle after request, no faults.
- LOAD bytes 13 00 50 00 B3 82 62 00, drop prog_en, fetch 0x0 and 0x4 → 0x00500013 and 0x006282B3, words_loaded = 2. Word 2 is still 0x00000013.
- Fetch 0x6 → misaligned = 1, out_of_range = 0, instruction_out = 0x00000013. Fetch 0x100 with DEPTH=64 → out_of_range = 1.
- LOAD 4·DEPTH + 4 bytes → words_loaded = DEPTH, prog_overflow = 1, last word dropped. Word 0 equals the first loaded word.
- LOAD 6 bytes then drop prog_en → words_loaded = 1. Word 1 is unchanged. Fetch asserted during LOAD and on the entry cycle → instr_valid never asserts.
- Assert reset for one cycle midway through a LOAD → CLEAR restarts, words_loaded = 0. After DEPTH cycles all words read 0x00000013.

Source files
------------

// File: rtl/instr_mem_prog.sv
// Programmable instruction memory: clears every word to FILL_WORD after reset,
// loads programs over a byte-serial port, and serves registered fetches with fault flags.
module instr_mem_prog #(
    parameter int                DEPTH     = 64,
    parameter int                ADDR_W    = 32,
    parameter int                WORD_W    = 32,
    parameter logic [WORD_W-1:0] FILL_WORD = WORD_W'(32'h00000013)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         prog_en,
    input  logic                         prog_valid,
    input  logic [7:0]                   prog_byte,
    output logic                         prog_ready,
    output logic                         prog_overflow,
    output logic [$clog2(DEPTH+1)-1:0]   words_loaded,
    output logic                         busy,
    input  logic                         fetch_req,
    input  logic [ADDR_W-1:0]            read_address,
    output logic [WORD_W-1:0]            instruction_out,
    output logic                         instr_valid,
    output logic                         misaligned,
    output logic                         out_of_range
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int LANES  = WORD_W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_READY = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [IDX_W-1:0]    clr_ptr;
    logic [LANE_W-1:0]   lane;
    logic [WORD_W-1:0]   asm_q;
    logic [WORD_W-1:0]   word_full;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                last_lane;
    logic                word_done;
    logic                mem_full;
    logic                fetch_go;
    logic                fetch_mis;
    logic                fetch_oor;
    logic [IDX_W-1:0]    fetch_idx;

    always_comb begin
        state_nx = state;
        case (state)
            ST_CLEAR: if (clr_ptr == IDX_W'(DEPTH-1)) state_nx = ST_READY;
            ST_READY: if (prog_en) state_nx = ST_LOAD;
            ST_LOAD:  if (!prog_en) state_nx = ST_READY;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    assign prog_ready = (state == ST_LOAD);
    assign accept     = prog_valid && prog_ready;
    assign last_lane  = (lane == LANE_W'(LANES-1));
    assign word_done  = accept && last_lane;
    // words_loaded doubles as the write pointer: both restart at 0 on LOAD entry.
    assign mem_full   = (words_loaded == CNT_W'(DEPTH));

    always_comb begin
        word_full = asm_q;
        word_full[lane*8 +: 8] = prog_byte;
    end

    assign fetch_go  = (state == ST_READY) && !prog_en && fetch_req;
    assign fetch_mis = (read_address[1:0] != 2'b00);
    assign fetch_oor = ((read_address >> 2) >= ADDR_W'(DEPTH));
    assign fetch_idx = read_address[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_CLEAR;
            busy            <= 1'b1;
            clr_ptr         <= '0;
            lane            <= '0;
            asm_q           <= '0;
            words_loaded    <= '0;
            prog_overflow   <= 1'b0;
            instr_valid     <= 1'b0;
            misaligned      <= 1'b0;
            out_of_range    <= 1'b0;
            instruction_out <= FILL_WORD;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != ST_READY);

            if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;

            if (state == ST_READY && prog_en) begin
                lane          <= '0;
                words_loaded  <= '0;
                prog_overflow <= 1'b0;
            end

            if (accept) begin
                asm_q <= word_full;
                lane  <= last_lane ? '0 : lane + 1'b1;
                if (last_lane) begin
                    if (mem_full) prog_overflow <= 1'b1;
                    else          words_loaded  <= words_loaded + 1'b1;
                end
            end

            instr_valid <= fetch_go;
            if (fetch_go) begin
                // Misaligned wins: an out-of-range flag is only raised on aligned addresses.
                misaligned      <= fetch_mis;
                out_of_range    <= !fetch_mis && fetch_oor;
                instruction_out <= (fetch_mis || fetch_oor) ? FILL_WORD : mem[fetch_idx];
            end else begin
                misaligned   <= 1'b0;
                out_of_range <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR)
                mem[clr_ptr] <= FILL_WORD;
            else if (word_done && !mem_full)
                mem[words_loaded[IDX_W-1:0]] <= word_full;
        end
    end

endmodule

// File: tb/tb_instr_mem_prog.sv
// Bench for instr_mem_prog: sweep timing, table-driven fetch vectors, program loads with
// overflow and partial words, randomized fetch streams against a word-array model.
module tb_instr_mem_prog;

    localparam int          DEPTH = 64;
    localparam logic [31:0] FILL  = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_en;
    logic        prog_valid;
    logic [7:0]  prog_byte;
    logic        prog_ready;
    logic        prog_overflow;
    logic [6:0]  words_loaded;
    logic        busy;
    logic        fetch_req;
    logic [31:0] read_address;
    logic [31:0] instruction_out;
    logic        instr_valid;
    logic        misaligned;
    logic        out_of_range;

    always #5 clk = ~clk;

    instr_mem_prog #(
        .DEPTH(DEPTH), .ADDR_W(32), .WORD_W(32), .FILL_WORD(FILL)
    ) dut (
        .clk(clk), .reset(reset),
        .prog_en(prog_en), .prog_valid(prog_valid), .prog_byte(prog_byte),
        .prog_ready(prog_ready), .prog_overflow(prog_overflow),
        .words_loaded(words_loaded), .busy(busy),
        .fetch_req(fetch_req), .read_address(read_address),
        .instruction_out(instruction_out), .instr_valid(instr_valid),
        .misaligned(misaligned), .out_of_range(out_of_range)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        mis;
        logic        oor;
    } vec_t;

    vec_t        vecs[8];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [DEPTH];
    logic [7:0]  byte_q [$];
    logic [34:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected response {valid, misaligned, out_of_range, data} from the word model.
    function automatic logic [34:0] model_fetch(input logic [31:0] a);
        logic        mis;
        logic        oor;
        logic [31:0] d;
        mis = (a % 4) != 0;
        oor = !mis && ((a / 4) >= DEPTH);
        d   = FILL;
        if (!mis && !oor) d = model_mem[a / 4];
        return {1'b1, mis, oor, d};
    endfunction

    task automatic fill_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = FILL;
    endtask

    task automatic fetch_check(input string name, input logic [31:0] a);
        logic [34:0] e;
        e = model_fetch(a);
        fetch_req    = 1'b1;
        read_address = a;
        @(negedge clk);
        fetch_req = 1'b0;
        check({name, ".valid"}, instr_valid, 1'b1);
        check({name, ".data"},  instruction_out, e[31:0]);
        check({name, ".mis"},   misaligned, e[33]);
        check({name, ".oor"},   out_of_range, e[32]);
    endtask

    task automatic wait_sweep(input string name);
        int cnt;
        bit saw;
        cnt = 0;
        saw = 0;
        fetch_req    = 1'b1;
        read_address = 32'h0;
        while (busy && cnt < 1000) begin
            cnt++;
            if (instr_valid) saw = 1;
            @(negedge clk);
        end
        if (instr_valid) saw = 1;
        fetch_req = 1'b0;
        check({name, ".busy_cycles"}, cnt, DEPTH);
        check({name, ".fetch_dropped"}, saw, 0);
    endtask

    task automatic load_run(input string name, input bit with_fetch, input bit gaps);
        int nw;
        bit saw;
        saw          = 0;
        prog_en      = 1'b1;
        fetch_req    = with_fetch;
        read_address = $urandom_range(0, DEPTH-1) * 4;
        @(negedge clk);
        if (instr_valid) saw = 1;
        check({name, ".ready_on_entry"}, prog_ready, 1'b1);
        check({name, ".busy_on_entry"}, busy, 1'b1);
        foreach (byte_q[i]) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    prog_valid = 1'b0;
                    @(negedge clk);
                    if (instr_valid) saw = 1;
                end
            end
            prog_valid = 1'b1;
            prog_byte  = byte_q[i];
            @(negedge clk);
            if (instr_valid) saw = 1;
        end
        prog_valid = 1'b0;
        prog_en    = 1'b0;
        @(negedge clk);
        if (instr_valid) saw = 1;
        fetch_req = 1'b0;
        check({name, ".ready_after_exit"}, prog_ready, 1'b0);
        check({name, ".busy_after_exit"}, busy, 1'b0);
        check({name, ".no_fetch_in_load"}, saw, 0);
        nw = byte_q.size() / 4;
        for (int w = 0; w < nw && w < DEPTH; w++)
            model_mem[w] = {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
        check({name, ".words_loaded"}, words_loaded, (nw > DEPTH) ? DEPTH : nw);
        check({name, ".overflow"}, prog_overflow, nw > DEPTH);
    endtask

    task automatic random_fetch_stream(input int n);
        logic [34:0] e;
        logic [34:0] got;
        logic [31:0] last;
        logic [31:0] a;
        bit          req;
        last = FILL;
        for (int i = 0; i < n; i++) begin
            req = (i == 0) || ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       a = $urandom();
                1:       a = $urandom_range(DEPTH-2, DEPTH+1) * 4 + $urandom_range(0, 1) * $urandom_range(1, 3);
                default: a = $urandom_range(0, DEPTH-1) * 4;
            endcase
            fetch_req    = req;
            read_address = a;
            if (req) begin
                e    = model_fetch(a);
                last = e[31:0];
            end else begin
                e = {3'b000, last};
            end
            exp_q.push_back(e);
            @(negedge clk);
            got = {instr_valid, misaligned, out_of_range, instruction_out};
            e   = exp_q.pop_front();
            check($sformatf("stream[%0d]", i), got, e);
        end
        fetch_req = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        prog_en      = 1'b0;
        prog_valid   = 1'b0;
        prog_byte    = 8'h00;
        fetch_req    = 1'b0;
        read_address = 32'h0;

        vecs[0] = '{addr: 32'h000, data: 32'h00500013, mis: 1'b0, oor: 1'b0};
        vecs[1] = '{addr: 32'h004, data: 32'h006282B3, mis: 1'b0, oor: 1'b0};
        vecs[2] = '{addr: 32'h008, data: FILL,         mis: 1'b0, oor: 1'b0};
        vecs[3] = '{addr: 32'h006, data: FILL,         mis: 1'b1, oor: 1'b0};
        vecs[4] = '{addr: 32'h100, data: FILL,         mis: 1'b0, oor: 1'b1};
        vecs[5] = '{addr: 32'h0FC, data: FILL,         mis: 1'b0, oor: 1'b0};
        vecs[6] = '{addr: 32'h103, data: FILL,         mis: 1'b1, oor: 1'b0};
        vecs[7] = '{addr: 32'h001, data: FILL,         mis: 1'b1, oor: 1'b0};

        repeat (3) @(negedge clk);
        check("rst.busy",         busy, 1'b1);
        check("rst.prog_ready",   prog_ready, 1'b0);
        check("rst.overflow",     prog_overflow, 1'b0);
        check("rst.words_loaded", words_loaded, 0);
        check("rst.instr_valid",  instr_valid, 1'b0);
        check("rst.mis",          misaligned, 1'b0);
        check("rst.oor",          out_of_range, 1'b0);
        check("rst.instr_out",    instruction_out, FILL);
        reset = 1'b0;
        fill_model();

        wait_sweep("sweep1");
        fetch_check("clr_0x0",  32'h0);
        fetch_check("clr_0x4",  32'h4);
        fetch_check("clr_0xfc", 32'hFC);

        byte_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h82, 8'h62, 8'h00};
        load_run("load2", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            fetch_req    = 1'b1;
            read_address = vecs[i].addr;
            @(negedge clk);
            fetch_req = 1'b0;
            check($sformatf("vec[%0d].valid", i), instr_valid, 1'b1);
            check($sformatf("vec[%0d].data", i),  instruction_out, vecs[i].data);
            check($sformatf("vec[%0d].mis", i),   misaligned, vecs[i].mis);
            check($sformatf("vec[%0d].oor", i),   out_of_range, vecs[i].oor);
        end
        @(negedge clk);
        check("hold.valid", instr_valid, 1'b0);
        check("hold.data",  instruction_out, FILL);

        byte_q.delete();
        repeat (4*DEPTH + 4) byte_q.push_back(8'($urandom()));
        load_run("load_full", 1'b0, 1'b1);
        fetch_check("full_w0",  32'h0);
        fetch_check("full_w63", 32'hFC);
        random_fetch_stream(300);

        byte_q.delete();
        repeat (6) byte_q.push_back(8'($urandom()));
        load_run("load_part", 1'b1, 1'b0);
        fetch_check("part_w0", 32'h0);
        fetch_check("part_w1", 32'h4);
        fetch_check("part_w2", 32'h8);

        prog_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            prog_valid = 1'b1;
            prog_byte  = 8'($urandom());
            @(negedge clk);
        end
        reset      = 1'b1;
        prog_valid = 1'b0;
        prog_en    = 1'b0;
        @(negedge clk);
        check("midrst.busy",         busy, 1'b1);
        check("midrst.words_loaded", words_loaded, 0);
        check("midrst.prog_ready",   prog_ready, 1'b0);
        reset = 1'b0;
        fill_model();
        wait_sweep("sweep2");
        for (int w = 0; w < DEPTH; w++) fetch_check($sformatf("clr2_w%0d", w), 32'(w * 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
